// File: rtl/hypot_pkg.sv
// rtl/hypot_pkg.sv - shared widths, state codes and saturation helper for hypot_unit
package hypot_pkg;

    localparam int OP_W     = 8;
    localparam int SUM_W    = 17;
    localparam int ROOT_W   = 9;
    localparam int MUL_CYC  = 8;
    localparam int SQRT_CYC = 9;

    localparam logic [OP_W-1:0] Y_MAX = 8'd255;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_MUL_A = 3'd1;
    localparam state_t ST_MUL_B = 3'd2;
    localparam state_t ST_SQRT  = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    function automatic logic [OP_W-1:0] sat_root(input logic [ROOT_W-1:0] r);
        return (r > ROOT_W'(Y_MAX)) ? Y_MAX : r[OP_W-1:0];
    endfunction

endpackage

// File: rtl/isqrt_seq.sv
// rtl/isqrt_seq.sv - restoring bit-pair integer square root, fixed 9-cycle latency
module isqrt_seq
    import hypot_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SUM_W-1:0]  radicand,
    output logic              done,
    output logic [ROOT_W-1:0] root
);

    localparam int REM_W = 12;

    logic [SUM_W:0]      rad_q, rad_d, src_rad;
    logic [REM_W-1:0]    rem_q, rem_d, src_rem, rem_sh, trial;
    logic [ROOT_W-1:0]   root_q, root_d, src_root, root_step;
    logic [3:0]          cnt_q, cnt_d;
    logic                run_q, run_d;
    logic                ge;

    // The start cycle already performs the first iteration straight from the
    // radicand input, so the ninth iteration lands in the ninth cycle.
    always_comb begin
        src_rad   = start ? {1'b0, radicand} : rad_q;
        src_rem   = start ? '0 : rem_q;
        src_root  = start ? '0 : root_q;
        rem_sh    = (src_rem << 2) | {{(REM_W-2){1'b0}}, src_rad[SUM_W:SUM_W-1]};
        trial     = {1'b0, src_root, 2'b01};
        ge        = (rem_sh >= trial);
        root_step = (src_root << 1) | {{(ROOT_W-1){1'b0}}, ge};
        done      = run_q && (cnt_q == 4'(SQRT_CYC - 1));
        root      = root_step;

        rad_d  = rad_q;
        rem_d  = rem_q;
        root_d = root_q;
        cnt_d  = cnt_q;
        run_d  = run_q;

        if (start || run_q) begin
            rad_d  = src_rad << 2;
            rem_d  = ge ? (rem_sh - trial) : rem_sh;
            root_d = root_step;
            cnt_d  = start ? 4'd1 : cnt_q + 4'd1;
            run_d  = start ? 1'b1 : !done;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
        end else begin
            rad_q  <= rad_d;
            rem_q  <= rem_d;
            root_q <= root_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
        end
    end

endmodule

// File: rtl/hypot_unit.sv
// rtl/hypot_unit.sv - iterative floor(sqrt(a*a+b*b)) with 8-bit saturating result
module hypot_unit
    import hypot_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    output logic            ready,
    output logic            busy,
    output logic [OP_W-1:0] y
);

    state_t              state_q, state_d;
    logic [OP_W-1:0]     a_q, a_d, b_q, b_d;
    logic [2*OP_W-1:0]   mcand_q, mcand_d;
    logic [SUM_W-1:0]    acc_q, acc_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [OP_W-1:0]     y_q, y_d;
    logic                mul_bit;
    logic                sqrt_start;
    logic                sqrt_done;
    logic [ROOT_W-1:0]   sqrt_root;

    isqrt_seq u_isqrt (
        .clk      (clk),
        .rst      (rst),
        .start    (sqrt_start),
        .radicand (acc_q),
        .done     (sqrt_done),
        .root     (sqrt_root)
    );

    // Both squares share one adder: the multiplier bit is picked from the
    // operand belonging to the current phase while the multiplicand shifts.
    assign mul_bit = (state_q == ST_MUL_A) ? a_q[cnt_q[2:0]] : b_q[cnt_q[2:0]];

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        mcand_d    = mcand_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        y_d        = y_q;
        sqrt_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    mcand_d = {{OP_W{1'b0}}, a};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_MUL_A;
                end
            end
            ST_MUL_A, ST_MUL_B: begin
                if (mul_bit) begin
                    acc_d = acc_q + {1'b0, mcand_q};
                end
                mcand_d = mcand_q << 1;
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == 4'(MUL_CYC - 1)) begin
                    cnt_d = '0;
                    if (state_q == ST_MUL_A) begin
                        mcand_d = {{OP_W{1'b0}}, b_q};
                        state_d = ST_MUL_B;
                    end else begin
                        state_d = ST_SQRT;
                    end
                end
            end
            ST_SQRT: begin
                sqrt_start = (cnt_q == 4'd0);
                cnt_d      = cnt_q + 4'd1;
                if (sqrt_done) begin
                    y_d     = sat_root(sqrt_root);
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
        end
    end

    assign ready = (state_q == ST_IDLE);
    assign busy  = (state_q == ST_MUL_A) || (state_q == ST_MUL_B) || (state_q == ST_SQRT);
    assign y     = y_q;

endmodule

// File: tb/tb_hypot_unit.sv
// tb/tb_hypot_unit.sv - table, corner-sequence and random checks of hypot_unit
module tb_hypot_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       ready;
    logic       busy;
    logic [7:0] y;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    hypot_unit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ready (ready),
        .busy  (busy),
        .y     (y)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    function automatic int ref_hypot(input int av, input int bv);
        int s;
        int r;
        s = av * av + bv * bv;
        r = 0;
        while ((r + 1) * (r + 1) <= s) r++;
        return (r > 255) ? 255 : r;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (ready && busy) begin
                failures++;
                $display("FAIL ready_busy_exclusive got=both expected=not_both");
            end
        end
    end

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("reset_ready", ready, 1);
        check("reset_busy", busy, 0);
        check("reset_y", y, 0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic launch(input logic [7:0] av, input logic [7:0] bv);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input bit perturb, output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (perturb) begin
                a     = 8'($urandom);
                b     = 8'($urandom);
                start = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic run_vec(input string name, input logic [7:0] av, input logic [7:0] bv,
                           input int exp);
        int n;
        do_reset();
        launch(av, bv);
        wait_done(1'b0, n);
        check({name, "_latency"}, n, 25);
        check({name, "_ready"}, ready, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_y"}, y, exp);
    endtask

    initial begin
        int n;
        logic [7:0] ra;
        logic [7:0] rb;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;

        vecs.push_back('{8'd3,   8'd4,   8'd5});
        vecs.push_back('{8'd5,   8'd12,  8'd13});
        vecs.push_back('{8'd8,   8'd15,  8'd17});
        vecs.push_back('{8'd9,   8'd12,  8'd15});
        vecs.push_back('{8'd1,   8'd1,   8'd1});
        vecs.push_back('{8'd2,   8'd2,   8'd2});
        vecs.push_back('{8'd1,   8'd5,   8'd5});
        vecs.push_back('{8'd10,  8'd20,  8'd22});
        vecs.push_back('{8'd15,  8'd6,   8'd16});
        vecs.push_back('{8'd55,  8'd55,  8'd77});
        vecs.push_back('{8'd8,   8'd9,   8'd12});
        vecs.push_back('{8'd255, 8'd255, 8'd255});
        vecs.push_back('{8'd200, 8'd200, 8'd255});
        vecs.push_back('{8'd180, 8'd0,   8'd180});
        vecs.push_back('{8'd0,   8'd0,   8'd0});
        vecs.push_back('{8'd0,   8'd7,   8'd7});

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            run_vec($sformatf("vec%0d_%0d_%0d", i, vecs[i].a, vecs[i].b),
                    vecs[i].a, vecs[i].b, int'(vecs[i].exp));
        end

        // Operands and start wiggle throughout the computation.
        do_reset();
        launch(8'd3, 8'd4);
        wait_done(1'b1, n);
        check("perturb_latency", n, 25);
        check("perturb_y", y, 5);

        // start while in DONE must change nothing.
        for (int i = 0; i < 4; i++) begin
            a     = 8'($urandom);
            b     = 8'($urandom);
            start = 1'b1;
            @(negedge clk);
            check("done_start_ready", ready, 0);
            check("done_start_busy", busy, 0);
            check("done_start_y", y, 5);
        end
        start = 1'b0;

        // Asynchronous reset in the tenth busy cycle.
        do_reset();
        launch(8'd200, 8'd100);
        for (int i = 1; i < 10; i++) @(negedge clk);
        check("midrst_busy_before", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_ready", ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_y", y, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        launch(8'd8, 8'd15);
        wait_done(1'b0, n);
        check("after_midrst_latency", n, 25);
        check("after_midrst_y", y, 17);

        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (i < 8) rb = 8'($urandom_range(0, 15));
            run_vec($sformatf("rand_%0d_%0d", ra, rb), ra, rb, ref_hypot(int'(ra), int'(rb)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hypot_unit.md
Name: hypot_unit

Overview:
- Sequential integer hypotenuse calculator: y = floor(sqrt(a*a + b*b)) on 8-bit unsigned operands.
- Result saturates to 8 bits.
- Single start/busy/ready handshake; the result stays valid until the next reset.
- Standalone arithmetic leaf block, shared-resource (iterative) implementation, no DSP inference required.

Parameters:
None (operand/result width fixed at 8; internal widths derived below).

Ports:
clk    input   1  system clock, all state on rising edge
rst    input   1  asynchronous, active-high reset; forces IDLE
start  input   1  launch request, sampled on rising clk while in IDLE
a      input   8  unsigned operand, captured on the accepted start edge
b      input   8  unsigned operand, captured on the accepted start edge
ready  output  1  1 only in IDLE (block can accept start)
busy   output  1  1 only while computing
y      output  8  result, valid when ready=0 and busy=0 (DONE)

Behaviour:
- States: IDLE, MUL_A, MUL_B, SQRT, DONE (encoding free).
- Reset (async, any state, including mid-computation): state=IDLE, ready=1, busy=0, y=0, all internal registers cleared.
- IDLE:
  - ready=1, busy=0.
  - On a rising edge with start=1: latch a, b into internal registers and go to MUL_A.
  - Later changes to a/b have no effect on the current computation.
- MUL_A:
  - busy=1, ready=0.
  - 8-cycle shift-add computes a*a (16 bits) into a 17-bit accumulator.
- MUL_B:
  - 8-cycle shift-add adds b*b into the accumulator.
  - Sum s is at most 130050 and fits in 17 bits.
- SQRT:
  - 9-cycle restoring bit-by-bit integer square root of s.
  - Produces a 9-bit root r = floor(sqrt(s)), r <= 360.
- Entry to DONE:
  - y <= (r > 255) ? 255 : r[7:0].
  - busy=0, ready=0.
- Latency: busy is high for exactly 25 consecutive cycles, starting the cycle after the accepted start edge; y is valid on the first DONE cycle.
- DONE:
  - Holds y indefinitely.
  - start is ignored; only rst returns to IDLE.
  - y keeps its value until reset clears it.
- start held high across the launch edge: no effect beyond the single launch.
- start while busy: ignored.
- y during IDLE/busy: holds the previous value (0 after reset).
- ready and busy are never simultaneously 1.
- Exact floor semantics, no rounding:
  - 1,1 -> 1
  - 2,2 -> 2
  - 55,55 -> 77
- Zero operands are legal: 0,0 -> 0; 0,7 -> 7.

Decomposition:
- Shared package hypot_pkg:
  - state enum (IDLE, MUL_A, MUL_B, SQRT, DONE)
  - constants OP_W=8, SUM_W=17, ROOT_W=9, MUL_CYC=8, SQRT_CYC=9, Y_MAX=255
- One natural sub-module: isqrt_seq (17-bit in, 9-bit out, start/done, 9-cycle fixed latency).
- The shift-add multiply and the FSM stay in the top.

Test Plan:
- Reset behaviour: rst=1 -> ready=1, busy=0, y=0; release rst, start=1 with a=3, b=4 -> busy=1 for exactly 25 cycles, then ready=0, busy=0, y=5.
- Pythagorean triples, each run preceded by a reset:
  - 5,12 -> 13
  - 8,15 -> 17
  - 9,12 -> 15
- Floor cases:
  - 1,1 -> 1
  - 2,2 -> 2
  - 1,5 -> 5
  - 10,20 -> 22
  - 15,6 -> 16
  - 55,55 -> 77
  - 8,9 -> 12
- Saturation and edges:
  - 255,255 -> 255
  - 200,200 -> 255
  - 180,0 -> 180
  - 0,0 -> 0
- Operand/start robustness: change a/b and toggle start during busy -> result unaffected (3,4 still gives 5); start in DONE -> state and y unchanged.
- Async reset mid-computation: assert rst at cycle 10 of busy -> immediately ready=1, busy=0, y=0; a new start then computes correctly.
